// File: rtl/spi_rx_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_rx_buffer_if
//  Description : Shifter handshake and host read-port bundle for the SPI
//                receive holding buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface spi_rx_buffer_if #(
  parameter int WIDTH  = 8,
  parameter int AWIDTH = 2
) ();
  // Shift-register side
  logic [WIDTH-1:0]  RXB_ShiftData_In;
  logic              RXB_ShiftValidN;
  logic              RXB_ShiftAckN;
  logic              RXB_CmdN;
  // Host side
  logic              RXB_ReadN;
  logic              RXB_ClrOvrN;
  logic [WIDTH-1:0]  RXB_Data_Out;
  logic              RXB_Empty;
  logic              RXB_Full;
  logic [AWIDTH:0]   RXB_Count;
  logic              RXB_Overrun;

  // Buffer view
  modport slave (
    input  RXB_ShiftData_In, RXB_ShiftValidN, RXB_CmdN, RXB_ReadN, RXB_ClrOvrN,
    output RXB_ShiftAckN, RXB_Data_Out, RXB_Empty, RXB_Full, RXB_Count, RXB_Overrun
  );

  // Shifter/host view
  modport master (
    output RXB_ShiftData_In, RXB_ShiftValidN, RXB_CmdN, RXB_ReadN, RXB_ClrOvrN,
    input  RXB_ShiftAckN, RXB_Data_Out, RXB_Empty, RXB_Full, RXB_Count, RXB_Overrun
  );
endinterface
`default_nettype wire

// File: rtl/spi_rx_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : spi_rx_buffer
//  Description : SPI receive holding buffer. Takes bytes from the shifter via
//                a four-phase ValidN/AckN handshake into a DEPTH-entry
//                circular FIFO with show-ahead read and sticky overrun.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_rx_buffer #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int AWIDTH = 2
) (
  input  wire             RXB_Clk,
  input  wire             RXB_Rst,
  spi_rx_buffer_if.slave  bus
);

  localparam logic [AWIDTH:0] c_DEPTH = DEPTH[AWIDTH:0];

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_t;

  state_t            r_state;
  logic              r_ack_n;
  logic              r_valid_q;
  logic [AWIDTH-1:0] r_wr_ptr;
  logic [AWIDTH-1:0] r_rd_ptr;
  logic [AWIDTH:0]   r_count;
  logic              r_overrun;
  logic [WIDTH-1:0]  r_mem [DEPTH];

  logic w_empty;
  logic w_full;
  logic w_take;
  logic w_pop;
  logic w_room;
  logic w_wr;
  logic w_drop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_DEPTH);
  // The FSM only ever looks at the resynchronised valid, never the pin.
  assign w_take  = (r_state == ST_IDLE) && r_valid_q;
  assign w_pop   = !bus.RXB_ReadN && !w_empty;
  // A pop in the take cycle frees the slot the incoming byte needs.
  assign w_room  = !w_full || w_pop;
  assign w_wr    = w_take && bus.RXB_CmdN && w_room;
  assign w_drop  = w_take && bus.RXB_CmdN && !w_room;

  // Handshake FSM: one byte taken per ValidN low period, AckN registered.
  always_ff @(posedge RXB_Clk or posedge RXB_Rst) begin
    if (RXB_Rst) begin
      r_state <= ST_IDLE;
      r_ack_n <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_valid_q) begin
            r_ack_n <= 1'b0;
            r_state <= ST_ACK;
          end
        end
        ST_ACK: begin
          if (!r_valid_q) begin
            r_ack_n <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_ack_n <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Input sampling, pointers, occupancy and sticky overrun.
  always_ff @(posedge RXB_Clk or posedge RXB_Rst) begin
    if (RXB_Rst) begin
      r_valid_q <= 1'b0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_valid_q <= !bus.RXB_ShiftValidN;
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_wr && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_wr && w_pop) begin
        r_count <= r_count - 1'b1;
      end
      // A drop in the same cycle as a clear leaves the flag set.
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (!bus.RXB_ClrOvrN) begin
        r_overrun <= 1'b0;
      end
    end
  end

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge RXB_Clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= bus.RXB_ShiftData_In;
    end
  end

  assign bus.RXB_ShiftAckN = r_ack_n;
  assign bus.RXB_Data_Out  = w_empty ? {WIDTH{1'b1}} : r_mem[r_rd_ptr];
  assign bus.RXB_Empty     = w_empty;
  assign bus.RXB_Full      = w_full;
  assign bus.RXB_Count     = r_count;
  assign bus.RXB_Overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_spi_rx_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_rx_buffer
//  Description : Directed self-checking bench for spi_rx_buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_rx_buffer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  spi_rx_buffer_if #(.WIDTH(8), .AWIDTH(2)) bus ();

  spi_rx_buffer #(.WIDTH(8), .DEPTH(4), .AWIDTH(2)) dut (
    .RXB_Clk (clk),
    .RXB_Rst (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full four-phase handshake; optional pop and/or overrun clear at the take edge.
  task automatic hs(input logic [7:0] d, input bit pop, input bit clr);
    bus.RXB_ShiftData_In = d;
    bus.RXB_ShiftValidN  = 1'b0;
    tick();
    chk("ack_before_take", 32'(bus.RXB_ShiftAckN), 32'd1);
    if (pop) bus.RXB_ReadN = 1'b0;
    if (clr) bus.RXB_ClrOvrN = 1'b0;
    tick();
    bus.RXB_ReadN   = 1'b1;
    bus.RXB_ClrOvrN = 1'b1;
    chk("ack_after_take", 32'(bus.RXB_ShiftAckN), 32'd0);
    bus.RXB_ShiftValidN = 1'b1;
    tick();
    chk("ack_hold", 32'(bus.RXB_ShiftAckN), 32'd0);
    tick();
    chk("ack_release", 32'(bus.RXB_ShiftAckN), 32'd1);
  endtask

  // Check the show-ahead head byte, then pop it.
  task automatic rd(input logic [7:0] exp);
    chk("read_data", 32'(bus.RXB_Data_Out), 32'(exp));
    bus.RXB_ReadN = 1'b0;
    tick();
    bus.RXB_ReadN = 1'b1;
  endtask

  initial begin
    bus.RXB_ShiftData_In = 8'h00;
    bus.RXB_ShiftValidN  = 1'b1;
    bus.RXB_CmdN         = 1'b1;
    bus.RXB_ReadN        = 1'b1;
    bus.RXB_ClrOvrN      = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_ack",   32'(bus.RXB_ShiftAckN), 32'd1);
    chk("rst_empty", 32'(bus.RXB_Empty),     32'd1);
    chk("rst_full",  32'(bus.RXB_Full),      32'd0);
    chk("rst_count", 32'(bus.RXB_Count),     32'd0);
    chk("rst_ovr",   32'(bus.RXB_Overrun),   32'd0);
    chk("rst_data",  32'(bus.RXB_Data_Out),  32'hFF);

    // 1: single byte through, then pop
    hs(8'hA5, 1'b0, 1'b0);
    chk("t1_empty", 32'(bus.RXB_Empty),    32'd0);
    chk("t1_count", 32'(bus.RXB_Count),    32'd1);
    rd(8'hA5);
    chk("t1_empty_after", 32'(bus.RXB_Empty),    32'd1);
    chk("t1_data_after",  32'(bus.RXB_Data_Out), 32'hFF);

    // 2: fill, overflow (clear coincident with drop must lose), drain, clear
    for (int i = 1; i <= 4; i++) hs(8'(i), 1'b0, 1'b0);
    chk("t2_full",  32'(bus.RXB_Full),  32'd1);
    chk("t2_count", 32'(bus.RXB_Count), 32'd4);
    chk("t2_ovr0",  32'(bus.RXB_Overrun), 32'd0);
    hs(8'h05, 1'b0, 1'b1);
    chk("t2_ovr_set",   32'(bus.RXB_Overrun), 32'd1);
    chk("t2_count_drop", 32'(bus.RXB_Count),  32'd4);
    for (int i = 1; i <= 4; i++) rd(8'(i));
    chk("t2_empty", 32'(bus.RXB_Empty), 32'd1);
    chk("t2_ovr_sticky", 32'(bus.RXB_Overrun), 32'd1);
    bus.RXB_ClrOvrN = 1'b0;
    tick();
    bus.RXB_ClrOvrN = 1'b1;
    chk("t2_ovr_clr", 32'(bus.RXB_Overrun), 32'd0);

    // 3: take and pop in the same cycle on a full queue
    for (int i = 1; i <= 4; i++) hs(8'(i), 1'b0, 1'b0);
    hs(8'h09, 1'b1, 1'b0);
    chk("t3_count", 32'(bus.RXB_Count),   32'd4);
    chk("t3_ovr",   32'(bus.RXB_Overrun), 32'd0);
    rd(8'h02);
    rd(8'h03);
    rd(8'h04);
    rd(8'h09);
    chk("t3_empty", 32'(bus.RXB_Empty), 32'd1);

    // 4: command mode discards but still acks
    bus.RXB_CmdN = 1'b0;
    hs(8'h3C, 1'b0, 1'b0);
    bus.RXB_CmdN = 1'b1;
    chk("t4_count", 32'(bus.RXB_Count),   32'd0);
    chk("t4_ovr",   32'(bus.RXB_Overrun), 32'd0);
    chk("t4_data",  32'(bus.RXB_Data_Out), 32'hFF);

    // 5: pointer wrap with interleaved write/read
    for (int i = 0; i < 10; i++) begin
      hs(8'h10 + 8'(i), 1'b0, 1'b0);
      chk("t5_count1", 32'(bus.RXB_Count), 32'd1);
      rd(8'h10 + 8'(i));
      chk("t5_count0", 32'(bus.RXB_Count), 32'd0);
    end
    bus.RXB_ReadN = 1'b0;
    tick();
    bus.RXB_ReadN = 1'b1;
    chk("t5_pop_empty_count", 32'(bus.RXB_Count), 32'd0);
    chk("t5_pop_empty_flag",  32'(bus.RXB_Empty), 32'd1);

    // 6: asynchronous reset while in ACK with two entries
    hs(8'h20, 1'b0, 1'b0);
    bus.RXB_ShiftData_In = 8'h21;
    bus.RXB_ShiftValidN  = 1'b0;
    tick();
    tick();
    chk("t6_in_ack",  32'(bus.RXB_ShiftAckN), 32'd0);
    chk("t6_count2",  32'(bus.RXB_Count),     32'd2);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_ack",   32'(bus.RXB_ShiftAckN), 32'd1);
    chk("t6_rst_empty", 32'(bus.RXB_Empty),     32'd1);
    chk("t6_rst_count", 32'(bus.RXB_Count),     32'd0);
    chk("t6_rst_data",  32'(bus.RXB_Data_Out),  32'hFF);
    bus.RXB_ShiftValidN = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    hs(8'h77, 1'b0, 1'b0);
    chk("t6_data",  32'(bus.RXB_Data_Out), 32'h77);
    chk("t6_count", 32'(bus.RXB_Count),    32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_rx_buffer.md
Name: spi_rx_buffer

Overview:
- Receive-direction holding buffer for the SPI path. It is the counterpart of the transmit holding register.
- Accepts completed bytes from the SPI shift register through a four-phase ValidN/AckN handshake and queues them in a DEPTH-entry circular FIFO.
- Presents the head byte to the host read port, show-ahead.
- Flags sticky overrun when the shifter delivers a byte while the queue is full. The shifter cannot stall, so that byte is dropped.

Parameters:
WIDTH, 8, data width in bits
DEPTH, 4, number of entries; must equal 2**AWIDTH
AWIDTH, 2, pointer width in bits

Ports:
RXB_Clk  in  1  clock; all logic on posedge
RXB_Rst  in  1  asynchronous, active-high reset
RXB_ShiftData_In  in  WIDTH  byte from the SPI shift register; stable while RXB_ShiftValidN is low
RXB_ShiftValidN  in  1  active low; the shift register has a completed byte
RXB_ShiftAckN  out  1  active low; the byte has been taken (stored or discarded)
RXB_CmdN  in  1  active low; command mode, in which received bytes are discarded
RXB_ReadN  in  1  active low; one-cycle host pop strobe
RXB_ClrOvrN  in  1  active low; clears the overrun flag
RXB_Data_Out  out  WIDTH  head entry; all ones when empty
RXB_Empty  out  1  queue is empty
RXB_Full  out  1  count equals DEPTH
RXB_Count  out  AWIDTH+1  number of occupied entries
RXB_Overrun  out  1  sticky; set when a byte is dropped because the queue is full

Behaviour:
- Reset (RXB_Rst high, asynchronous), applied immediately, including mid-handshake:
  - wr_ptr=0, rd_ptr=0, count=0, FSM=IDLE, valid_q=0
  - RXB_ShiftAckN=1, RXB_Empty=1, RXB_Full=0, RXB_Overrun=0, RXB_Data_Out=all ones
  - Array contents are don't-care.
- Input sampling: valid_q <= ~RXB_ShiftValidN on every posedge. The FSM acts only on valid_q, never on the raw pin.
- Handshake FSM:
  - IDLE: if valid_q=1, take the byte (see "Take" below), drive AckN low and go to ACK. Otherwise stay in IDLE.
  - ACK: AckN held low. When valid_q=0, drive AckN high and go to IDLE.
  - Latency, shift side: ValidN falls before edge N → valid_q set at N → capture and AckN low at edge N+1.
  - Latency, release: ValidN rises before edge M → AckN high after edge M+1.
  - A new ValidN low edge while in ACK is not a new byte. Exactly one byte is taken per handshake.
- Take, evaluated at the take edge:
  - RXB_CmdN=0: discard the byte. No write, no overrun change; ack is still given.
  - Otherwise, if count<DEPTH, or count==DEPTH with a valid pop in the same cycle: write mem[wr_ptr] <= RXB_ShiftData_In, and wr_ptr increments.
  - Otherwise: drop the byte and set RXB_Overrun=1. Ack is still given.
- Read: RXB_ReadN=0 with count>0 → rd_ptr increments. RXB_ReadN=0 while empty is ignored; pointers and count are unchanged, with no error.
- Pointers wrap modulo DEPTH through natural AWIDTH-bit rollover.
- Count update: write only → +1; pop only → −1; write and pop in the same cycle → unchanged. Count is never outside 0..DEPTH.
- Status: RXB_Empty=(count==0) and RXB_Full=(count==DEPTH). Both are registered-state derived and update in the same edge as count.
- RXB_Data_Out = mem[rd_ptr] when count>0, else all ones.
  - Data written into an empty queue is visible after the take edge.
  - No cycle of latency is added on pop.
- Overrun:
  - Set by a drop.
  - Cleared synchronously when RXB_ClrOvrN=0.
  - A set and a clear in the same cycle resolve to set.
- RXB_CmdN changing mid-handshake has effect only at the take edge.

Test Plan:
1. Reset, then one handshake of 8'hA5 → AckN low 2 edges after ValidN falls; Empty=0, Count=1, Data_Out=A5. Release ValidN → AckN high 2 edges later. Pulse ReadN → Empty=1, Data_Out=FF.
2. Four bytes 01,02,03,04 with no reads → Full=1, Count=4. Fifth byte 05 → acked, dropped, Overrun=1. Four reads return 01,02,03,04 in order. ClrOvrN pulse → Overrun=0.
3. Full queue, ReadN low in the same cycle as the take of 09 → Count stays 4, no overrun. The queue drains 02,03,04,09.
4. CmdN=0 during a handshake of 3C → acked, Count stays 0, Overrun stays 0.
5. Pointer wrap: ten interleaved write/read pairs of 10..19 → each read matches its write. Count alternates 1/0. ReadN while empty leaves Count=0.
6. Assert RXB_Rst while in ACK with Count=2 → AckN=1, Empty=1, Count=0 immediately. After reset a fresh handshake of 77 → Data_Out=77.
